// File: rtl/qix_palette.sv
// qix_palette: palette RAM and two-stage pixel colour pipeline.
//
// The palette RAM holds 1024 bytes, organised as 4 banks of 256 entries.
// Each entry is packed as R[7:6] G[5:4] B[3:2] I[1:0]. A bank register picks
// which bank the display uses; the CPU always addresses all 1024 bytes directly.
//
// Ports:
//   clk_20m      system clock; all logic runs on its rising edge
//   reset        asynchronous active-high reset
//   ce_pix       pixel clock enable (one clk_20m cycle in four)
//   pixel_index  palette index of the current pixel
//   blank_in     high outside the active display area, aligned with pixel_index
//   rgb_r/g/b    expanded 8-bit colour, valid 2 ce_pix pulses after the pixel
//   blank_out    blank_in delayed to line up with rgb_*
//   cpu_cs       one-cycle palette RAM access strobe
//   cpu_rw       1 = read, 0 = write
//   cpu_addr     {bank[1:0], index[7:0]} byte address
//   cpu_di       CPU write data
//   cpu_do       CPU read data, registered one cycle after the read strobe
//   bank_we      one-cycle strobe that loads bank_di into the bank register
//   bank_di      new display bank
module qix_palette #(
    parameter logic [1:0] BANK_RESET = 2'd0
) (
    input  logic       clk_20m,
    input  logic       reset,
    input  logic       ce_pix,
    input  logic [7:0] pixel_index,
    input  logic       blank_in,
    output logic [7:0] rgb_r,
    output logic [7:0] rgb_g,
    output logic [7:0] rgb_b,
    output logic       blank_out,
    input  logic       cpu_cs,
    input  logic       cpu_rw,
    input  logic [9:0] cpu_addr,
    input  logic [7:0] cpu_di,
    output logic [7:0] cpu_do,
    input  logic       bank_we,
    input  logic [1:0] bank_di
);

    logic [7:0] mem [1024];

    logic [1:0] bank_q;
    logic [7:0] s1_entry_q;
    logic       s1_blank_q;

    // A zero colour field is black. Otherwise the {c,i} nibble is copied into
    // both halves of the byte (the same as multiplying it by 17).
    function automatic logic [7:0] expand(input logic [1:0] c, input logic [1:0] i);
        if (c == 2'd0) begin
            return 8'd0;
        end
        return {c, i, c, i};
    endfunction

    // The RAM has no reset, so its contents survive a reset.
    always_ff @(posedge clk_20m) begin
        if (cpu_cs && !cpu_rw) begin
            mem[cpu_addr] <= cpu_di;
        end
    end

    always_ff @(posedge clk_20m or posedge reset) begin
        if (reset) begin
            cpu_do <= 8'd0;
        end else if (cpu_cs && cpu_rw) begin
            cpu_do <= mem[cpu_addr];
        end
    end

    // A lookup in the same cycle as bank_we still uses the old bank.
    always_ff @(posedge clk_20m or posedge reset) begin
        if (reset) begin
            bank_q <= BANK_RESET;
        end else if (bank_we) begin
            bank_q <= bank_di;
        end
    end

    // Stage 1 reads the RAM through its own port. If the CPU writes the same
    // address in the same cycle, this read returns the old data.
    always_ff @(posedge clk_20m or posedge reset) begin
        if (reset) begin
            s1_entry_q <= 8'd0;
            s1_blank_q <= 1'b1;
        end else if (ce_pix) begin
            s1_entry_q <= mem[{bank_q, pixel_index}];
            s1_blank_q <= blank_in;
        end
    end

    // Stage 2: expand the colour and force black during blanking.
    always_ff @(posedge clk_20m or posedge reset) begin
        if (reset) begin
            rgb_r     <= 8'd0;
            rgb_g     <= 8'd0;
            rgb_b     <= 8'd0;
            blank_out <= 1'b1;
        end else if (ce_pix) begin
            blank_out <= s1_blank_q;
            if (s1_blank_q) begin
                rgb_r <= 8'd0;
                rgb_g <= 8'd0;
                rgb_b <= 8'd0;
            end else begin
                rgb_r <= expand(s1_entry_q[7:6], s1_entry_q[1:0]);
                rgb_g <= expand(s1_entry_q[5:4], s1_entry_q[1:0]);
                rgb_b <= expand(s1_entry_q[3:2], s1_entry_q[1:0]);
            end
        end
    end

endmodule
